// File: rtl/fir_pkg.sv
// Shared constants for the fixed-coefficient 8-tap low-pass FIR.
`ifndef WIDTH
`define WIDTH 16
`endif

package fir_pkg;

  localparam int WIDTH  = `WIDTH;
  localparam int NTAPS  = 8;
  localparam int COEF_W = 16;
  localparam int FRAC   = 15;

  // Products are kept at full precision; the accumulator adds log2(NTAPS)
  // guard bits so the sum of all taps can never wrap.
  localparam int PROD_W = WIDTH + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);

  typedef logic signed [COEF_W-1:0] coef_t;

  // Symmetric Q1.15 taps summing to 32768, giving unity DC gain.
  localparam coef_t COEFS [0:NTAPS-1] = '{
    16'sd1024, 16'sd2048, 16'sd4096, 16'sd9216,
    16'sd9216, 16'sd4096, 16'sd2048, 16'sd1024
  };

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and clamp from accumulator width to sample width.
module fir_round_sat
  import fir_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [WIDTH-1:0] o_sample
);

  // One extra bit so adding the rounding constant cannot overflow.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] RND     = RW'(2 ** (FRAC - 1));
  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (WIDTH - 1)));

  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_shift;

  assign w_rnd   = RW'(i_acc) + RND;
  // Arithmetic shift floors, so together with +half this rounds toward +inf.
  assign w_shift = w_rnd >>> FRAC;

  // Clamp the shifted value into the representable sample range.
  always_comb begin
    o_sample = w_shift[WIDTH-1:0];
    if (w_shift > SAT_MAX) begin
      o_sample = SAT_MAX[WIDTH-1:0];
    end else if (w_shift < SAT_MIN) begin
      o_sample = SAT_MIN[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_impl.sv
// 8-tap direct-form FIR: delay line -> products -> accumulator -> round/sat output.
module fir_impl
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] sig_in,
  output logic signed [WIDTH-1:0] sig_out
);

  logic signed [WIDTH-1:0]  r_x [0:NTAPS-1];
  logic signed [PROD_W-1:0] r_p [0:NTAPS-1];
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [WIDTH-1:0]  r_out;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [WIDTH-1:0]  w_sat;

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      // Delay line: tap 0 takes the new sample, others shift along.
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_x[gi] <= '0;
          else        r_x[gi] <= sig_in;
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_x[gi] <= '0;
          else        r_x[gi] <= r_x[gi-1];
        end
      end

      // Full-precision product of each tap with its constant coefficient.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_p[gi] <= '0;
        else        r_p[gi] <= PROD_W'(r_x[gi]) * PROD_W'(COEFS[gi]);
      end
    end
  endgenerate

  // Exact sum of all products, sign-extended into the guarded width.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      w_sum = w_sum + ACC_W'(r_p[k]);
    end
  end

  // Accumulator stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= w_sum;
  end

  fir_round_sat u_round_sat (
    .i_acc    (r_acc),
    .o_sample (w_sat)
  );

  // Registered output sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= w_sat;
  end

  assign sig_out = r_out;

endmodule

// File: tb/tb_fir_impl.sv
// Directed self-checking bench for fir_impl.
module tb_fir_impl;
  import fir_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic signed [WIDTH-1:0] sig_in;
  logic signed [WIDTH-1:0] sig_out;

  int checks;
  int failures;

  fir_impl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .sig_out (sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // At a falling edge: observe the current output, then present the next sample.
  // The sample presented here is captured at the following rising edge; its
  // tap-0 contribution is observed four calls later.
  task automatic cycle(input int v, output int o);
    @(negedge clk);
    o = int'(sig_out);
    sig_in = WIDTH'(v);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    sig_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int o;
    rst_n  = 1'b0;
    sig_in = '0;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (sig_out !== '0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%0d want=0", i, sig_out);
      end
      sig_in = WIDTH'($urandom_range(0, 65535));
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Build up a nonzero output, then pull reset between edges.
    for (int i = 0; i < 12; i++) cycle(1000, o);
    checks++;
    if (o != 1000) begin
      failures++;
      $display("FAIL reset_pre_level got=%0d want=1000", o);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sig_out !== '0) begin
      failures++;
      $display("FAIL reset_async got=%0d want=0", sig_out);
    end
    @(negedge clk);
    sig_in = '0;
    rst_n  = 1'b1;
    // History must be gone: zeros in, zeros out.
    for (int i = 0; i < 12; i++) begin
      cycle(0, o);
      checks++;
      if (o != 0) begin
        failures++;
        $display("FAIL reset_history cyc=%0d got=%0d want=0", i, o);
      end
    end
  endtask

  task automatic test_impulse(input string name, input int amp, input int exp_seq [8]);
    int o;
    int want;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle((i == 0) ? amp : 0, o);
      want = (i >= 4 && i <= 11) ? exp_seq[i-4] : 0;
      checks++;
      if (o != want) begin
        failures++;
        $display("FAIL impulse_%s idx=%0d got=%0d want=%0d", name, i, o, want);
      end
    end
  endtask

  task automatic test_dc_step();
    int o;
    int ramp [8] = '{31, 94, 219, 500, 781, 906, 969, 1000};
    int want;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1000, o);
      want = (i < 4) ? 0 : ((i < 12) ? ramp[i-4] : 1000);
      checks++;
      if (o != want) begin
        failures++;
        $display("FAIL dc_step idx=%0d got=%0d want=%0d", i, o, want);
      end
    end
  endtask

  task automatic test_extremes(input int amp);
    int o;
    int prev;
    do_reset();
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(amp, o);
      // A step response of non-negative taps must move monotonically toward amp.
      checks++;
      if ((amp > 0 && (o < prev || o < 0)) || (amp < 0 && (o > prev || o > 0))) begin
        failures++;
        $display("FAIL extreme_mono amp=%0d idx=%0d got=%0d prev=%0d", amp, i, o, prev);
      end
      prev = o;
    end
    checks++;
    if (o != amp) begin
      failures++;
      $display("FAIL extreme_settle amp=%0d got=%0d want=%0d", amp, o, amp);
    end
  endtask

  task automatic test_alternating();
    int o;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle((i % 2 == 0) ? 8192 : -8192, o);
      if (i >= 11) begin
        checks++;
        if (o != 0) begin
          failures++;
          $display("FAIL alternating idx=%0d got=%0d want=0", i, o);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sig_in   = '0;
    test_reset();
    test_impulse("big",  16384, '{512, 1024, 2048, 4608, 4608, 2048, 1024, 512});
    test_impulse("pos16",   16, '{1, 1, 2, 5, 5, 2, 1, 1});
    test_impulse("neg16",  -16, '{0, -1, -2, -4, -4, -2, -1, 0});
    test_impulse("one",      1, '{0, 0, 0, 0, 0, 0, 0, 0});
    test_dc_step();
    test_extremes(32767);
    test_extremes(-32768);
    test_alternating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
